// File: rtl/ame_result_writer_if.sv
// AXI4 write-only master bundle (AW, W, B) used by ame_result_writer.
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid and ready are both 1; once valid is raised the source holds
// valid and its payload unchanged until that edge, and ready may toggle freely.
interface ame_result_writer_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64
);
  logic [ADDR_BITS-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ame_result_writer.sv
// ame_result_writer: captures the solver's affine results on a rising edge of
// comp_done_i and writes them to memory as one 64-byte-aligned AXI4 INCR burst.
// Optional feature macro: AME_WR_HDR_EN -- prepend a header beat carrying a
// 32-bit sequence number and the result count.
module ame_result_writer #(
  parameter int COMP_DATA_BITS = 64,
  parameter int RESULT_NUM     = 6,
  parameter int ADDR_BITS      = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     comp_done_i,
  input  logic                                     affine_param6_i,
  input  logic [RESULT_NUM-1:0][COMP_DATA_BITS-1:0] comp_data_i,
  input  logic [ADDR_BITS-1:0]                     base_addr_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     err_o,
  output logic                                     drop_o,
  output logic [1:0]                               state_o,
  ame_result_writer_if.master                      m_axi
);

`ifdef AME_WR_HDR_EN
  localparam logic [3:0] HDR_BEATS = 4'd1;
`else
  localparam logic [3:0] HDR_BEATS = 4'd0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                                    state;
  logic                                      comp_done_q;
  logic [RESULT_NUM-1:0][COMP_DATA_BITS-1:0] buffer;
  logic [3:0]                                first_q;
  logic [3:0]                                beats_q;
  logic [3:0]                                beat_k;
`ifdef AME_WR_HDR_EN
  logic [3:0]                                n_q;
  logic [31:0]                               seq_q;
`endif

  logic                      start_edge;
  logic [3:0]                n_next;
  logic [3:0]                beats_next;
  logic [3:0]                sel_idx;
  logic [3:0]                slot;
  logic                      sel_last;
  logic [COMP_DATA_BITS-1:0] sel_data;
  logic                      unused_addr_low;

  // Low address bits are forced to zero by the 64-byte alignment.
  assign unused_addr_low = ^base_addr_i[5:0];

  assign start_edge = comp_done_i & ~comp_done_q;
  assign n_next     = affine_param6_i ? 4'd6 : 4'd4;
  assign beats_next = n_next + HDR_BEATS;
  assign state_o    = state;

  // Fixed burst attributes: 8-byte beats, INCR, all byte lanes written.
  assign m_axi.awsize  = 3'h3;
  assign m_axi.awburst = 2'h1;
  assign m_axi.wstrb   = '1;

  // Select the payload of the beat about to be presented: beat 0 when
  // leaving ADDR, otherwise the beat after the one currently on the bus.
  always_comb begin
    sel_idx  = (state == ADDR) ? 4'd0 : beat_k + 4'd1;
    sel_last = (sel_idx == beats_q - 4'd1);
    sel_data = '0;
`ifdef AME_WR_HDR_EN
    slot = first_q + sel_idx - 4'd1;
`else
    slot = first_q + sel_idx;
`endif
    for (int i = 0; i < RESULT_NUM; i++) begin
      if (slot == 4'(i)) sel_data = buffer[i];
    end
`ifdef AME_WR_HDR_EN
    if (sel_idx == 4'd0) sel_data = {seq_q, 24'b0, 4'b0, n_q};
`endif
  end

  // Burst FSM with registered AXI outputs and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      comp_done_q   <= 1'b0;
      buffer        <= '0;
      first_q       <= 4'd0;
      beats_q       <= 4'd0;
      beat_k        <= 4'd0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      drop_o        <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.awlen   <= 8'd0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wlast   <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
`ifdef AME_WR_HDR_EN
      n_q           <= 4'd0;
      seq_q         <= 32'd0;
`endif
    end else begin
      comp_done_q <= comp_done_i;
      done_o      <= 1'b0;
      drop_o      <= 1'b0;
      case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (start_edge) begin
            buffer        <= comp_data_i;
            first_q       <= affine_param6_i ? 4'd0 : 4'd2;
            beats_q       <= beats_next;
            m_axi.awaddr  <= {base_addr_i[ADDR_BITS-1:6], 6'b0};
            m_axi.awlen   <= {4'b0, beats_next - 4'd1};
            m_axi.awvalid <= 1'b1;
            err_o         <= 1'b0;
            busy_o        <= 1'b1;
`ifdef AME_WR_HDR_EN
            n_q           <= n_next;
`endif
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b1;
            m_axi.wdata   <= sel_data;
            m_axi.wlast   <= sel_last;
            beat_k        <= 4'd0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (m_axi.wready) begin
            if (m_axi.wlast) begin
              m_axi.wvalid <= 1'b0;
              m_axi.wlast  <= 1'b0;
              m_axi.bready <= 1'b1;
              state        <= RESP;
            end else begin
              beat_k      <= beat_k + 4'd1;
              m_axi.wdata <= sel_data;
              m_axi.wlast <= sel_last;
            end
          end
        end
        RESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            err_o        <= (m_axi.bresp != 2'b00);
            done_o       <= 1'b1;
`ifdef AME_WR_HDR_EN
            seq_q        <= seq_q + 32'd1;
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A new result set while a burst is in flight cannot be stored.
      if (start_edge && (state != IDLE)) drop_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ame_result_writer.sv
// Testbench for ame_result_writer: configurable AXI slave, W-beat scoreboard
// and directed bursts covering both result counts, slave stalls, error
// responses, dropped starts and reset mid-burst.
module tb_ame_result_writer;

  logic                clk = 1'b0;
  logic                rst;
  logic                comp_done;
  logic                affine;
  logic [5:0][63:0]    comp_data;
  logic [31:0]         base_addr;
  logic                busy, done, err, drop;
  logic [1:0]          state;

  ame_result_writer_if m_axi ();

  ame_result_writer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .comp_done_i     (comp_done),
    .affine_param6_i (affine),
    .comp_data_i     (comp_data),
    .base_addr_i     (base_addr),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .drop_o          (drop),
    .state_o         (state),
    .m_axi           (m_axi)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] exp_aw_q[$];
  logic [7:0]  exp_len_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] seq_model = 32'd0;

  // slave configuration
  int          aw_delay = 0;
  int          b_delay = 0;
  bit          w_toggle = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;

  logic [5:0][63:0] data_a;
  logic [5:0][63:0] data_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- AXI slave model ----------------
  initial begin
    int aw_cnt;
    int b_cnt;
    aw_cnt = 0;
    b_cnt = 0;
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      m_axi.bresp = bresp_cfg;
      if (m_axi.awvalid) begin
        if (aw_cnt >= aw_delay) m_axi.awready = 1'b1;
        else begin
          m_axi.awready = 1'b0;
          aw_cnt++;
        end
      end else begin
        m_axi.awready = 1'b0;
        aw_cnt = 0;
      end
      if (m_axi.wvalid) m_axi.wready = w_toggle ? ~m_axi.wready : 1'b1;
      else m_axi.wready = 1'b0;
      if (m_axi.bready) begin
        if (!m_axi.bvalid) begin
          if (b_cnt >= b_delay) m_axi.bvalid = 1'b1;
          else b_cnt++;
        end
      end else begin
        m_axi.bvalid = 1'b0;
        b_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  logic        aw_open = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      aw_open = 1'b0;
    end else begin
      if (prev_stall) begin
        check("w_hold_valid", m_axi.wvalid, 1'b1);
        check("w_hold_data", m_axi.wdata, prev_data);
        check("w_hold_last", m_axi.wlast, prev_last);
      end
      if (m_axi.awvalid && m_axi.awready) begin
        check("aw_expected", exp_aw_q.size() != 0, 1'b1);
        if (exp_aw_q.size() != 0) begin
          check("awaddr", m_axi.awaddr, exp_aw_q.pop_front());
          check("awlen", m_axi.awlen, exp_len_q.pop_front());
        end
        aw_open = 1'b1;
      end
      if (m_axi.wvalid) check("w_after_aw", aw_open, 1'b1);
      if (m_axi.wvalid && m_axi.wready) begin
        check("w_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("wdata", m_axi.wdata, exp_q.pop_front());
          check("wlast", m_axi.wlast, exp_last_q.pop_front());
        end
      end
      if (m_axi.bvalid && m_axi.bready) aw_open = 1'b0;
      prev_stall = m_axi.wvalid & ~m_axi.wready;
      prev_data  = m_axi.wdata;
      prev_last  = m_axi.wlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_burst(input bit p6, input logic [31:0] base, input logic [5:0][63:0] data);
    int first;
    int n;
    first = p6 ? 0 : 2;
    n = p6 ? 6 : 4;
    comp_data = data;
    affine = p6;
    base_addr = base;
    exp_aw_q.push_back({base[31:6], 6'b0});
`ifdef AME_WR_HDR_EN
    exp_len_q.push_back(8'(n));
    exp_q.push_back({seq_model, 24'b0, 8'(n)});
    exp_last_q.push_back(1'b0);
`else
    exp_len_q.push_back(8'(n - 1));
`endif
    for (int k = first; k < 6; k++) begin
      exp_q.push_back(data[k]);
      exp_last_q.push_back(k == 5);
    end
    @(posedge clk);
    #1 comp_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("awvalid_latency", m_axi.awvalid, 1'b1);
    check("busy_after_start", busy, 1'b1);
    check("err_cleared_on_start", err, 1'b0);
  endtask

  task automatic wait_done(input logic exp_err);
    int cyc;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", done, 1'b1);
    if (done) begin
      check("busy_on_done", busy, 1'b1);
      check("err_after_done", err, exp_err);
      seq_model = seq_model + 32'd1;
      @(negedge clk);
      check("done_one_pulse", done, 1'b0);
      check("busy_clear", busy, 1'b0);
      check("err_sticky", err, exp_err);
      check("beats_all_seen", exp_q.size(), 0);
    end
    @(posedge clk);
    #1 comp_done = 1'b0;
  endtask

  task automatic wait_wvalid();
    int cyc;
    cyc = 0;
    while (!m_axi.wvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("wvalid_seen", m_axi.wvalid, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 6; i++) begin
      data_a[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0011;
      data_b[i] = 64'hFFFF_FFFF_FFFF_FFF0 - 64'(i) * 64'h0123_4567_0000_0001;
    end
    rst = 1'b1;
    comp_done = 1'b0;
    affine = 1'b0;
    comp_data = '0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", m_axi.awvalid, 1'b0);
    check("rst_wvalid", m_axi.wvalid, 1'b0);
    check("rst_wlast", m_axi.wlast, 1'b0);
    check("rst_bready", m_axi.bready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_drop", drop, 1'b0);
    check("rst_awaddr", m_axi.awaddr, 32'h0);
    check("rst_wdata", m_axi.wdata, 64'h0);
    check("rst_awsize", m_axi.awsize, 3'h3);
    check("rst_awburst", m_axi.awburst, 2'h1);
    check("rst_wstrb", m_axi.wstrb, 8'hff);
    check("rst_state", state, 2'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // six results, aligned base, always-ready slave
    start_burst(1'b1, 32'h1000_0040, data_a);
    wait_done(1'b0);

    // four results, unaligned base
    start_burst(1'b0, 32'h2000_0017, data_b);
    wait_done(1'b0);

    // slow slave: AW delay, toggling wready, late B
    aw_delay = 3;
    w_toggle = 1'b1;
    b_delay = 5;
    start_burst(1'b1, 32'h3000_0080, data_b);
    wait_done(1'b0);
    aw_delay = 0;
    w_toggle = 1'b0;
    b_delay = 0;

    // error response, then cleared by the next start
    bresp_cfg = 2'b10;
    start_burst(1'b0, 32'h4000_0000, data_a);
    wait_done(1'b1);
    bresp_cfg = 2'b00;
    start_burst(1'b1, 32'h4000_0100, data_a);
    wait_done(1'b0);

    // second start while busy: dropped, burst unaffected
    w_toggle = 1'b1;
    start_burst(1'b1, 32'h5000_0000, data_a);
    wait_wvalid();
    @(posedge clk);
    #1 comp_done = 1'b0;
    @(posedge clk);
    #1 comp_done = 1'b1;
    comp_data = data_b;
    affine = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_pulse", drop, 1'b1);
    @(negedge clk);
    check("drop_one_cycle", drop, 1'b0);
    wait_done(1'b0);

    // reset in the middle of the data phase
    start_burst(1'b1, 32'h6000_0000, data_b);
    wait_wvalid();
    #2 rst = 1'b1;
    #1;
    check("midrst_awvalid", m_axi.awvalid, 1'b0);
    check("midrst_wvalid", m_axi.wvalid, 1'b0);
    check("midrst_bready", m_axi.bready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    comp_done = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    exp_aw_q.delete();
    exp_len_q.delete();
    seq_model = 32'd0;
    w_toggle = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // two six-result runs after reset (header sequence 0 then 1 when enabled)
    start_burst(1'b1, 32'h7000_0040, data_a);
    wait_done(1'b0);
    start_burst(1'b1, 32'h7000_0080, data_b);
    wait_done(1'b0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
